// File: rtl/fp_div_unit_pkg.sv
// Shared float field widths, constants, FSM encodings and the special-case classifier.
package fp_div_unit_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned SIG_W   = MANT_W + 1;
    localparam int unsigned ITER    = 26;
    localparam int unsigned REM_W   = SIG_W + 1;
    localparam int unsigned EXPR_W  = 10;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned FP_BIAS = 127;

    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] FP_PINF = 32'h7F80_0000;

    // Denormal inputs are read as zero; underflowing results become signed zero.
    localparam bit FLUSH_DENORM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_DIVIDE,
        ST_NORM,
        ST_PACK,
        ST_DONE
    } div_state_e;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [SIG_W-1:0]  mant;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } fp_fields_t;

    // Decide which fixed answer (if any) replaces the computed quotient.
    function automatic special_e classify(input fp_fields_t a, input fp_fields_t b);
        special_e sp;
        sp = SP_NONE;
        if (a.is_nan || b.is_nan || (a.is_zero && b.is_zero) || (a.is_inf && b.is_inf))
            sp = SP_NAN;
        else if (b.is_zero || a.is_inf)
            sp = SP_INF;
        else if (a.is_zero || b.is_inf)
            sp = SP_ZERO;
        return sp;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of a single-precision float into fields plus class flags.
module fp_unpack
    import fp_div_unit_pkg::*;
(
    input  logic [FP_W-1:0] x,
    output fp_fields_t      fields_c
);

    logic [EXP_W-1:0]  exp_c;
    logic [MANT_W-1:0] frac_c;

    assign exp_c  = x[FP_W-2:MANT_W];
    assign frac_c = x[MANT_W-1:0];

    // Field split, hidden bit insertion and classification.
    always_comb begin
        fields_c         = '0;
        fields_c.sign    = x[FP_W-1];
        fields_c.exp     = exp_c;
        fields_c.mant    = {(exp_c != '0), frac_c};
        fields_c.is_nan  = (exp_c == '1) && (frac_c != '0);
        fields_c.is_inf  = (exp_c == '1) && (frac_c == '0);
        fields_c.is_zero = (exp_c == '0) && ((frac_c == '0) || FLUSH_DENORM);
    end

endmodule

// File: rtl/fp_div_unit.sv
// Multi-cycle single-precision divider, one restoring quotient bit per clock.
module fp_div_unit
    import fp_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [FP_W-1:0] dataa,
    input  logic [FP_W-1:0] datab,
    output logic [FP_W-1:0] result,
    output logic            done
);

    div_state_e               state;
    logic [FP_W-1:0]          a_r;
    logic [FP_W-1:0]          b_r;
    logic                     sign_r;
    logic signed [EXPR_W-1:0] exp_r;
    logic [SIG_W-1:0]         mb_r;
    logic [REM_W-1:0]         rem_r;
    logic [ITER-1:0]          q_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     sticky_r;
    special_e                 special_r;
    logic [FP_W-1:0]          pack_r;
    logic                     pack_ph_r;

    fp_fields_t               fa_c;
    fp_fields_t               fb_c;
    logic [REM_W:0]           trial_c;
    logic                     round_up_c;
    logic                     carry_c;
    logic [MANT_W-1:0]        frac_c;
    logic signed [EXPR_W-1:0] exp_rnd_c;
    logic [FP_W-1:0]          pack_c;

    fp_unpack u_unpack_a (.x(a_r), .fields_c(fa_c));
    fp_unpack u_unpack_b (.x(b_r), .fields_c(fb_c));

    // Trial subtraction for the current restoring step; MSB set means negative.
    assign trial_c = {1'b0, rem_r} - {2'b00, mb_r};

    // Round-to-nearest-even on the normalised quotient and final packing.
    always_comb begin
        round_up_c        = q_r[1] & (q_r[0] | sticky_r | q_r[2]);
        {carry_c, frac_c} = (MANT_W+1)'({1'b0, q_r[ITER-2:2]}) + (MANT_W+1)'(round_up_c);
        exp_rnd_c         = carry_c ? exp_r + EXPR_W'(1) : exp_r;
        pack_c            = '0;
        case (special_r)
            SP_NAN:  pack_c = FP_QNAN;
            SP_INF:  pack_c = {sign_r, FP_PINF[FP_W-2:0]};
            SP_ZERO: pack_c = {sign_r, (FP_W-1)'(0)};
            default: begin
                if (exp_rnd_c >= $signed(EXPR_W'(255)))
                    pack_c = {sign_r, FP_PINF[FP_W-2:0]};
                else if (exp_rnd_c <= $signed(EXPR_W'(0)))
                    pack_c = {sign_r, (FP_W-1)'(0)};
                else
                    pack_c = {sign_r, exp_rnd_c[EXP_W-1:0], frac_c};
            end
        endcase
    end

    // Control FSM and datapath registers; enable low before DONE aborts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            mb_r      <= '0;
            rem_r     <= '0;
            q_r       <= '0;
            cnt_r     <= '0;
            sticky_r  <= 1'b0;
            special_r <= SP_NONE;
            pack_r    <= '0;
            pack_ph_r <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
        end else if (!enable && (state != ST_IDLE) && (state != ST_DONE)) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        a_r   <= dataa;
                        b_r   <= datab;
                        state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    sign_r    <= fa_c.sign ^ fb_c.sign;
                    exp_r     <= $signed({2'b00, fa_c.exp}) - $signed({2'b00, fb_c.exp})
                                 + $signed(EXPR_W'(FP_BIAS));
                    rem_r     <= {1'b0, fa_c.mant};
                    mb_r      <= fb_c.mant;
                    q_r       <= '0;
                    cnt_r     <= '0;
                    special_r <= classify(fa_c, fb_c);
                    state     <= ST_DIVIDE;
                end
                ST_DIVIDE: begin
                    if (!trial_c[REM_W]) begin
                        q_r   <= {q_r[ITER-2:0], 1'b1};
                        rem_r <= {trial_c[SIG_W-1:0], 1'b0};
                    end else begin
                        q_r   <= {q_r[ITER-2:0], 1'b0};
                        rem_r <= {rem_r[SIG_W-1:0], 1'b0};
                    end
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(ITER - 1))
                        state <= ST_NORM;
                end
                ST_NORM: begin
                    sticky_r <= (rem_r != '0);
                    if (!q_r[ITER-1]) begin
                        q_r   <= {q_r[ITER-2:0], 1'b0};
                        exp_r <= exp_r - EXPR_W'(1);
                    end
                    pack_ph_r <= 1'b0;
                    state     <= ST_PACK;
                end
                ST_PACK: begin
                    if (!pack_ph_r) begin
                        pack_r    <= pack_c;
                        pack_ph_r <= 1'b1;
                    end else begin
                        result <= pack_r;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_unit.sv
// Directed and randomized checks of fp_div_unit against an exact-division model.
module tb_fp_div_unit;

    localparam int LAT = 30;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    int checks = 0;
    int errors = 0;

    fp_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Exact quotient via wide integer division, then round-to-nearest-even.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        int          ea, eb, e, sh;
        logic [22:0] fa, fb;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
        logic [63:0] num, den, q, r, kept, rest, half;
        sign   = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        fa     = a[22:0];
        fb     = b[22:0];
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC00000;
        if (b_zero || a_inf) return {sign, 31'h7F800000};
        if (a_zero || b_inf) return {sign, 31'h0};
        num  = {40'd1, fa} << 32;
        den  = {40'd1, fb};
        q    = num / den;
        r    = num % den;
        e    = ea - eb + 127;
        if (q >= 64'h1_0000_0000) sh = 9;
        else begin
            sh = 8;
            e  = e - 1;
        end
        kept = q >> sh;
        rest = q & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        up   = (rest > half) || ((rest == half) && ((r != 0) || kept[0]));
        kept = kept + 64'(up);
        if (kept == 64'h100_0000) begin
            kept = kept >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {sign, 31'h7F800000};
        if (e <= 0) return {sign, 31'h0};
        return {sign, 8'(e), kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int          sel;
        logic [31:0] v;
        sel = int'($urandom_range(0, 19));
        v   = $urandom;
        case (sel)
            0:       v[30:0] = 31'h0;
            1:       v[30:0] = 31'h7F800000;
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'h00;
            4, 5:    v[30:23] = 8'($urandom_range(1, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start an operation and wait (bounded) for done; operands are scrambled after sampling.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        dataa  = a;
        datab  = b;
        enable = 1'b1;
        @(posedge clk);
        #1;
        dataa = $urandom;
        datab = $urandom;
        lat   = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, 32'(done), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        run_op(a, b, res, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_res"}, res, exp);
        finish_op(tag);
    endtask

    initial begin
        logic [31:0] a, b, res, prev;
        int          lat;
        logic        saw_done;

        clk    = 1'b0;
        reset  = 1'b0;
        enable = 1'b0;
        dataa  = '0;
        datab  = '0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        do_op("div_6_2", 32'h40C00000, 32'h40000000, 32'h40400000);
        do_op("div_1_3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB);
        do_op("div_m1_4", 32'hBF800000, 32'h40800000, 32'hBE800000);
        do_op("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000);
        do_op("zero_by_zero", 32'h80000000, 32'h00000000, 32'h7FC00000);
        do_op("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000);
        do_op("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        do_op("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000);
        do_op("underflow", 32'h00800000, 32'h4B000000, 32'h00000000);

        for (int i = 0; i < 40; i++) begin
            a = rand_fp();
            b = rand_fp();
            do_op("rand", a, b, ref_div(a, b));
        end

        // Abort: drop enable after edge 10; done must never rise, result untouched.
        prev = result;
        @(negedge clk);
        dataa  = 32'h40400000;
        datab  = 32'h3F800000;
        enable = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        enable   = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        chk("abort_result", result, prev);
        do_op("after_abort", 32'h40400000, 32'h3F800000, 32'h40400000);

        // Hold enable past done: outputs stay put.
        a = 32'h41200000;
        b = 32'h40A00000;
        run_op(a, b, res, lat);
        chk("hold_lat", 32'(lat), 32'(LAT));
        chk("hold_res", res, 32'h40000000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_result", result, 32'h40000000);
        end
        finish_op("hold");
        do_op("back2back", 32'hC1100000, 32'h40400000, 32'hC0400000);

        // Reset in the middle of the divide loop.
        @(negedge clk);
        dataa  = 32'h40C00000;
        datab  = 32'h40000000;
        enable = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'h0);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_done_hold", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
